mem_access_ctrl: RTL

- Sequencing memory-access controller that sits directly upstream of the ROM/RAM output mux.
- Accepts one load/store request at a time from the datapath and decodes the byte address into the ROM (text) or RAM (data) region.
- Drives the selected memory's word index, enable and write strobe for a parameterised number of wait cycles.
- Presents the region base on Selector_o for the downstream mux, registers the muxed read data and pulses a completion flag.

---
 rtl/mem_access_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the ROM/RAM output mux: decodes the byte
// address, drives one memory for a fixed number of wait cycles, returns data.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter logic [31:0] ROM_BASE   = 32'h00400000,
  parameter logic [31:0] RAM_BASE   = 32'h10010000,
  parameter int unsigned ROM_WORDS  = 64,
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned RAM_WAIT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_i,
  input  logic                  We_i,
  input  logic [31:0]           Addr_i,
  input  logic [DATA_WIDTH-1:0] Wdata_i,
  input  logic [DATA_WIDTH-1:0] Mux_data_i,
  output logic                  Ready_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [DATA_WIDTH-1:0] Rdata_o,
  output logic [31:0]           Selector_o,
  output logic                  Rom_en_o,
  output logic [IDX_WIDTH-1:0]  Rom_addr_o,
  output logic                  Ram_en_o,
  output logic                  Ram_we_o,
  output logic [IDX_WIDTH-1:0]  Ram_addr_o,
  output logic [DATA_WIDTH-1:0] Ram_wdata_o
);

  localparam int unsigned CNT_WIDTH = 4;

  // Region ends computed on 33 bits so a region touching the top of the
  // address space cannot wrap.
  localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] ROM_HI = ROM_LO + (33'(ROM_WORDS) << 2);
  localparam logic [32:0] RAM_HI = RAM_LO + (33'(RAM_WORDS) << 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   store_q, store_d;

  logic                   ready_d;
  logic                   done_d;
  logic                   error_d;
  logic [DATA_WIDTH-1:0]  rdata_d;
  logic [31:0]            sel_d;
  logic                   rom_en_d;
  logic [IDX_WIDTH-1:0]   rom_addr_d;
  logic                   ram_en_d;
  logic                   ram_we_d;
  logic [IDX_WIDTH-1:0]   ram_addr_d;
  logic [DATA_WIDTH-1:0]  ram_wdata_d;

  logic [32:0]            addr_ext;
  logic                   rom_hit;
  logic                   ram_hit;
  logic                   req_err;
  logic [IDX_WIDTH-1:0]   rom_idx;
  logic [IDX_WIDTH-1:0]   ram_idx;

  // Address decode of the incoming request
  always_comb begin
    addr_ext = {1'b0, Addr_i};
    rom_hit  = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
    ram_hit  = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
    req_err  = (Addr_i[1:0] != 2'b00) || (!rom_hit && !ram_hit) || (We_i && rom_hit);
    rom_idx  = IDX_WIDTH'((Addr_i - ROM_BASE) >> 2);
    ram_idx  = IDX_WIDTH'((Addr_i - RAM_BASE) >> 2);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    done_d      = 1'b0;
    error_d     = Error_o;
    rdata_d     = Rdata_o;
    sel_d       = Selector_o;
    rom_en_d    = Rom_en_o;
    rom_addr_d  = Rom_addr_o;
    ram_en_d    = Ram_en_o;
    ram_we_d    = Ram_we_o;
    ram_addr_d  = Ram_addr_o;
    ram_wdata_d = Ram_wdata_o;

    case (state_q)
      S_IDLE: begin
        if (Req_i) begin
          store_d = We_i;
          if (req_err) begin
            done_d  = 1'b1;
            error_d = 1'b1;
            state_d = S_RESP;
          end else if (rom_hit) begin
            rom_addr_d = rom_idx;
            sel_d      = ROM_BASE;
            rom_en_d   = 1'b1;
            cnt_d      = CNT_WIDTH'(ROM_WAIT);
            state_d    = S_ACCESS;
          end else begin
            ram_addr_d = ram_idx;
            sel_d      = RAM_BASE;
            ram_en_d   = 1'b1;
            ram_we_d   = We_i;
            if (We_i) begin
              ram_wdata_d = Wdata_i;
            end
            cnt_d   = CNT_WIDTH'(RAM_WAIT);
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          if (!store_q) begin
            rdata_d = Mux_data_i;
          end
          rom_en_d = 1'b0;
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        error_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        rom_en_d = 1'b0;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        error_d  = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      Ready_o     <= 1'b1;
      Done_o      <= 1'b0;
      Error_o     <= 1'b0;
      Rdata_o     <= '0;
      Selector_o  <= ROM_BASE;
      Rom_en_o    <= 1'b0;
      Rom_addr_o  <= '0;
      Ram_en_o    <= 1'b0;
      Ram_we_o    <= 1'b0;
      Ram_addr_o  <= '0;
      Ram_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      Ready_o     <= ready_d;
      Done_o      <= done_d;
      Error_o     <= error_d;
      Rdata_o     <= rdata_d;
      Selector_o  <= sel_d;
      Rom_en_o    <= rom_en_d;
      Rom_addr_o  <= rom_addr_d;
      Ram_en_o    <= ram_en_d;
      Ram_we_o    <= ram_we_d;
      Ram_addr_o  <= ram_addr_d;
      Ram_wdata_o <= ram_wdata_d;
    end
  end

endmodule
